// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache refill and dcache read/write traffic onto one memory channel
// with write > read > instr priority, instr anti-starvation and an ack timeout.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MAXWAIT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iadr,
    output logic [DW-1:0] idata,
    output logic          ival,
    input  logic          rreq,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdata,
    output logic          rval,
    input  logic          wreq,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    output logic          wval,
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] madr,
    output logic [DW-1:0] mwdata,
    input  logic [DW-1:0] mrdata,
    input  logic          mack,
    output logic          err,
    output logic [1:0]    grant,
    output logic          busy
);
    localparam int SW = $clog2(MAXWAIT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t state, next;
    logic [SW-1:0] scnt;
    logic [7:0] wcnt;
    logic [1:0] win;
    logic ack, tmo;
    always_comb begin
        win = (ireq && scnt == SW'(MAXWAIT)) ? 2'd1 : wreq ? 2'd3 : rreq ? 2'd2 : ireq ? 2'd1 : 2'd0;
        ack = state == ISSUE && mack;
        tmo = state == ISSUE && !mack && wcnt == 8'(TIMEOUT - 1);
        next = state == IDLE ? (win != 2'd0 ? ISSUE : IDLE) :
               state == ISSUE ? (ack || tmo ? DONE : ISSUE) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idata <= '0;
            rdata <= '0;
            ival <= 1'b0;
            rval <= 1'b0;
            wval <= 1'b0;
            mreq <= 1'b0;
            mwe <= 1'b0;
            madr <= '0;
            mwdata <= '0;
            err <= 1'b0;
            grant <= 2'd0;
            busy <= 1'b0;
            scnt <= '0;
            wcnt <= '0;
        end else begin
            mreq <= next == ISSUE;
            busy <= next != IDLE;
            ival <= 1'b0;
            rval <= 1'b0;
            wval <= 1'b0;
            err <= 1'b0;
            if (state == IDLE) begin
                // only data grants taken while ireq waits count towards starvation
                scnt <= (!ireq || win == 2'd1) ? '0 : (scnt != SW'(MAXWAIT)) ? scnt + 1'b1 : scnt;
                if (win != 2'd0) begin
                    grant <= win;
                    mwe <= win == 2'd3;
                    madr <= win == 2'd3 ? wadr : win == 2'd2 ? radr : iadr;
                    mwdata <= win == 2'd3 ? wdata : '0;
                    wcnt <= '0;
                end
            end
            if (state == ISSUE) begin
                wcnt <= wcnt + 1'b1;
                if (ack || tmo) begin
                    ival <= grant == 2'd1;
                    rval <= grant == 2'd2;
                    wval <= grant == 2'd3;
                    err <= tmo;
                    if (grant == 2'd1) idata <= ack ? mrdata : '0;
                    if (grant == 2'd2) rdata <= ack ? mrdata : '0;
                end
            end
            if (state == DONE) grant <= 2'd0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a randomized run against a priority/starvation model
// and a behavioural single-port memory with configurable ack latency.
module tb_mem_arbiter;
    localparam int MW = 4;
    localparam int TO = 8;
    logic clk = 0, reset = 1;
    logic ireq = 0, rreq = 0, wreq = 0, mack = 0;
    logic [31:0] iadr = 0, radr = 0, wadr = 0, wdata = 0, mrdata = 0;
    logic [31:0] idata, rdata, madr, mwdata;
    logic ival, rval, wval, mreq, mwe, err, busy;
    logic [1:0] grant;
    int n_cmp = 0, n_bad = 0;
    int k = 0, mcnt = 0;
    bit mem_en = 1, stray = 0, auto_drop = 1;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pre [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [32:0] mlog [$];
    int gq [$];
    logic [1:0] gprev = 0;
    int nv_i = 0, nv_r = 0, nv_w = 0;
    logic s_iv, s_rv, s_wv, s_err, s_mreq;
    logic [31:0] s_id, s_rd;

    mem_arbiter #(.AW(32), .DW(32), .MAXWAIT(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iadr(iadr), .idata(idata), .ival(ival),
        .rreq(rreq), .radr(radr), .rdata(rdata), .rval(rval),
        .wreq(wreq), .wadr(wadr), .wdata(wdata), .wval(wval),
        .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata), .mrdata(mrdata), .mack(mack),
        .err(err), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pre.exists(a) ? pre[a] : dflt(a);
    endfunction

    // memory: acks the k-th ISSUE cycle, logs every access in order
    always @(negedge clk) begin
        if (mreq && mem_en && mcnt == k) begin
            mack = 1'b1;
            if (mwe) mem[madr] = mwdata;
            mrdata = mwe ? 32'h0 : mem.exists(madr) ? mem[madr] : pre.exists(madr) ? pre[madr] : dflt(madr);
            mlog.push_back({mwe, madr});
        end else mack = stray;
        mcnt = mreq ? mcnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (grant != 2'd0 && gprev == 2'd0) gq.push_back(int'(grant));
        gprev = grant;
        nv_i += int'(ival);
        nv_r += int'(rval);
        nv_w += int'(wval);
    end

    task automatic tick;
        @(negedge clk);
        s_iv = ival; s_rv = rval; s_wv = wval; s_err = err; s_mreq = mreq; s_id = idata; s_rd = rdata;
        @(posedge clk);
        #1;
        if (auto_drop) begin
            if (s_iv) ireq = 0;
            if (s_rv) rreq = 0;
            if (s_wv) wreq = 0;
        end
    endtask

    task automatic wait_done(output bit ok, output int cyc);
        ok = 0;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cyc++;
            if (s_iv || s_rv || s_wv) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL done_wait: got no done pulse within 300 cycles, want one"); end
    endtask

    task automatic do_reset;
        reset = 1; ireq = 0; rreq = 0; wreq = 0; stray = 0; mem_en = 1; auto_drop = 1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset;
        bit ok;
        int c;
        @(negedge clk);
        n_cmp++;
        if ({idata, rdata, ival, rval, wval, mreq, mwe, madr, mwdata, err, grant, busy} !== '0) begin
            n_bad++; $display("FAIL reset_values: got idata=%h rdata=%h madr=%h grant=%0d busy=%b want all 0", idata, rdata, madr, grant, busy);
        end
        @(posedge clk);
        #1 reset = 0;
        mem_en = 0; radr = 32'h40; rreq = 1;
        tick(); tick();
        n_cmp++;
        if ({mreq, madr} !== {1'b1, 32'h40}) begin n_bad++; $display("FAIL issue_before_reset: got mreq=%b madr=%h want 1 00000040", mreq, madr); end
        @(negedge clk);
        reset = 1;
        #1;
        n_cmp++;
        if ({idata, rdata, ival, rval, wval, mreq, mwe, madr, mwdata, err, grant, busy} !== '0) begin
            n_bad++; $display("FAIL reset_mid_issue: got mreq=%b madr=%h grant=%0d busy=%b want all 0", mreq, madr, grant, busy);
        end
        @(posedge clk);
        #1 reset = 0;
        mem_en = 1; k = 1; pre[32'h40] = 32'hA1B2_C3D4;
        wait_done(ok, c);
        n_cmp++;
        if ({s_rv, s_err, s_rd} !== {2'b10, 32'hA1B2_C3D4}) begin n_bad++; $display("FAIL reset_reissue: got rval=%b err=%b rdata=%h want 1 0 a1b2c3d4", s_rv, s_err, s_rd); end
    endtask

    task automatic test_single_read;
        bit ok;
        int c;
        k = 2; pre[32'h100] = 32'hDEAD_BEEF; radr = 32'h100; rreq = 1;
        wait_done(ok, c);
        n_cmp++;
        if (c !== 5 || !s_rv) begin n_bad++; $display("FAIL read_latency: got rval=%b after %0d cycles want 1 after 5", s_rv, c); end
        n_cmp++;
        if ({s_err, s_rd} !== {1'b0, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL read_data: got err=%b rdata=%h want 0 deadbeef", s_err, s_rd); end
        repeat (3) tick();
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_hold: got %h want deadbeef", rdata); end
    endtask

    task automatic test_contention;
        int g0, m0, vi, vr, vw;
        g0 = gq.size(); m0 = mlog.size(); vi = nv_i; vr = nv_r; vw = nv_w;
        k = 0;
        iadr = 32'h280; radr = 32'h200; wadr = 32'h200; wdata = 32'h1234_5678;
        ireq = 1; rreq = 1; wreq = 1;
        for (int i = 0; i < 60 && (ireq || rreq || wreq); i++) tick();
        repeat (3) tick();
        n_cmp++;
        if (gq.size() - g0 !== 3) begin n_bad++; $display("FAIL cont_grant_count: got %0d want 3", gq.size() - g0); end
        else begin
            n_cmp++;
            if ({gq[g0], gq[g0+1], gq[g0+2]} !== {32'd3, 32'd2, 32'd1}) begin
                n_bad++; $display("FAIL cont_grant_order: got %0d %0d %0d want 3 2 1", gq[g0], gq[g0+1], gq[g0+2]);
            end
        end
        n_cmp++;
        if (mlog.size() - m0 < 2 || mlog[m0] !== {1'b1, 32'h200} || mlog[m0+1] !== {1'b0, 32'h200}) begin
            n_bad++; $display("FAIL cont_mem_order: got %0d accesses, first %h want write 200 then read 200", mlog.size() - m0, (mlog.size() > m0) ? mlog[m0] : 33'h0);
        end
        n_cmp++;
        if ({nv_i - vi, nv_r - vr, nv_w - vw} !== {32'd1, 32'd1, 32'd1}) begin
            n_bad++; $display("FAIL cont_val_pulses: got i=%0d r=%0d w=%0d want 1 1 1", nv_i - vi, nv_r - vr, nv_w - vw);
        end
        n_cmp++;
        if ({rdata, idata} !== {32'h1234_5678, dflt(32'h280)}) begin n_bad++; $display("FAIL cont_data: got rdata=%h idata=%h want 12345678 %h", rdata, idata, dflt(32'h280)); end
        ref_mem[32'h200] = 32'h1234_5678;
    endtask

    task automatic test_starvation;
        int g0, ms, e;
        do_reset();
        g0 = gq.size();
        k = 0; auto_drop = 0; iadr = 32'h600; radr = 32'h604;
        ireq = 1; rreq = 1;
        for (int i = 0; i < 200 && gq.size() - g0 < 10; i++) tick();
        ireq = 0; rreq = 0;
        for (int i = 0; i < 20 && busy; i++) tick();
        auto_drop = 1;
        n_cmp++;
        if (gq.size() - g0 < 10) begin n_bad++; $display("FAIL starve_count: got %0d grants want 10", gq.size() - g0); end
        else begin
            ms = 0;
            for (int i = 0; i < 10; i++) begin
                e = (ms == MW) ? 1 : 2;
                ms = (e == 1) ? 0 : ms + 1;
                n_cmp++;
                if (gq[g0+i] !== e) begin n_bad++; $display("FAIL starve_grant_%0d: got %0d want %0d", i, gq[g0+i], e); end
            end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int c, nm;
        k = 0; iadr = 32'h304; ireq = 1;
        wait_done(ok, c);
        n_cmp++;
        if (s_id !== dflt(32'h304)) begin n_bad++; $display("FAIL tmo_preload: got idata=%h want %h", s_id, dflt(32'h304)); end
        mem_en = 0; iadr = 32'h300; ireq = 1; nm = 0; ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            nm += int'(s_mreq);
            if (s_iv || s_rv || s_wv) begin ok = 1; break; end
        end
        n_cmp++;
        if (nm !== TO || !ok) begin n_bad++; $display("FAIL tmo_mreq_cycles: got %0d done=%b want %0d 1", nm, ok, TO); end
        n_cmp++;
        if ({s_iv, s_err, s_id} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL tmo_done: got ival=%b err=%b idata=%h want 1 1 0", s_iv, s_err, s_id); end
        n_cmp++;
        if ({busy, grant} !== 3'b000) begin n_bad++; $display("FAIL tmo_idle: got busy=%b grant=%0d want 0 0", busy, grant); end
        mem_en = 1;
    endtask

    task automatic test_late_ack;
        bit ok;
        int c, vi, vr, vw;
        k = TO - 1; pre[32'h500] = 32'hCAFE_F00D; radr = 32'h500; rreq = 1;
        tick(); tick(); tick();
        rreq = 0;
        wait_done(ok, c);
        n_cmp++;
        if ({s_rv, s_err, s_rd} !== {2'b10, 32'hCAFE_F00D}) begin n_bad++; $display("FAIL late_ack: got rval=%b err=%b rdata=%h want 1 0 cafef00d", s_rv, s_err, s_rd); end
        vi = nv_i; vr = nv_r; vw = nv_w;
        stray = 1;
        tick(); tick();
        stray = 0;
        tick(); tick();
        n_cmp++;
        if ({busy, grant, mreq} !== 4'b0 || nv_i + nv_r + nv_w !== vi + vr + vw) begin
            n_bad++; $display("FAIL stray_mack: got busy=%b grant=%0d mreq=%b extra_vals=%0d want 0 0 0 0", busy, grant, mreq, nv_i + nv_r + nv_w - vi - vr - vw);
        end
    endtask

    task automatic test_random;
        bit ok;
        int c, ms, e, p;
        logic [31:0] ea, ev;
        do_reset();
        ms = 0;
        for (int t = 0; t < 40; t++) begin
            if (!ireq && $urandom_range(0, 2) == 0) begin ireq = 1; iadr = 32'h0001_0000 | ($urandom_range(0, 15) << 2); end
            if (!rreq && $urandom_range(0, 2) == 0) begin rreq = 1; radr = 32'h0001_0000 | ($urandom_range(0, 15) << 2); end
            if (!wreq && $urandom_range(0, 2) == 0) begin wreq = 1; wadr = 32'h0001_0000 | ($urandom_range(0, 15) << 2); wdata = $urandom; end
            if (!(ireq || rreq || wreq)) begin rreq = 1; radr = 32'h0001_0000 | ($urandom_range(0, 15) << 2); end
            k = $urandom_range(0, 3);
            e = (ireq && ms == MW) ? 1 : wreq ? 3 : rreq ? 2 : 1;
            ms = (e == 1 || !ireq) ? 0 : (ms < MW ? ms + 1 : ms);
            ea = e == 3 ? wadr : e == 2 ? radr : iadr;
            ev = e == 3 ? wdata : ref_rd(ea);
            if (e == 3) ref_mem[wadr] = wdata;
            wait_done(ok, c);
            p = s_wv ? 3 : s_rv ? 2 : s_iv ? 1 : 0;
            n_cmp++;
            if (p !== e || s_err !== 1'b0) begin n_bad++; $display("FAIL rand_%0d_owner: got port=%0d err=%b want %0d 0", t, p, s_err, e); end
            n_cmp++;
            if (mlog.size() == 0 || mlog[mlog.size()-1] !== {e == 3, ea}) begin
                n_bad++; $display("FAIL rand_%0d_access: got %h want %h", t, (mlog.size() > 0) ? mlog[mlog.size()-1] : 33'h0, {e == 3, ea});
            end
            if (e != 3) begin
                n_cmp++;
                if ((e == 2 ? s_rd : s_id) !== ev) begin n_bad++; $display("FAIL rand_%0d_data: got %h want %h", t, e == 2 ? s_rd : s_id, ev); end
            end
        end
        ireq = 0; rreq = 0; wreq = 0;
        for (int i = 0; i < 300 && busy; i++) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 time units, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_starvation();
        test_timeout();
        test_late_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port backing memory between the icache refill port and the dcache read and write ports. It sits between `icache`/`dcache` and `mem`, replacing their three independent memory channels with one request/acknowledge channel. It serialises transactions, applies write > read > instruction priority with an instruction anti-starvation counter, and times out requests that the memory never acknowledges.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MAXWAIT`, 4, maximum number of consecutive data-port grants allowed while `ireq` is pending.
- `TIMEOUT`, 255, maximum number of cycles spent waiting for `mack` before the transaction is aborted. Range 1..255.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `ireq`  in  1  icache refill request.
- `iadr`  in  AW  icache refill address.
- `idata`  out  DW  icache refill data.
- `ival`  out  1  icache transaction done, one-cycle pulse.
- `rreq`  in  1  dcache read request.
- `radr`  in  AW  dcache read address.
- `rdata`  out  DW  dcache read data.
- `rval`  out  1  dcache read done, one-cycle pulse.
- `wreq`  in  1  dcache write request.
- `wadr`  in  AW  dcache write address.
- `wdata`  in  DW  dcache write data.
- `wval`  out  1  dcache write done, one-cycle pulse.
- `mreq`  out  1  memory request.
- `mwe`  out  1  memory write enable.
- `madr`  out  AW  memory address.
- `mwdata`  out  DW  memory write data.
- `mrdata`  in  DW  memory read data, valid when `mack` is high.
- `mack`  in  1  memory acknowledge.
- `err`  out  1  pulses together with the done pulse when a transaction timed out.
- `grant`  out  2  active owner: 0 none, 1 instr, 2 read, 3 write.
- `busy`  out  1  high when state is not IDLE.

## Operation
Requester protocol:
- A requester holds `req` and its address (and data, for writes) stable until its done pulse.
- After the done pulse it drops `req` at the following clock edge.
- If `req` is still high in IDLE after a done pulse, that is a new transaction.

State machine: IDLE, ISSUE, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise pick the winner and latch its address, data and `mwe` into the issue registers.
  - Set `grant` and go to ISSUE.
- **ISSUE**
  - Drive `mreq`=1 and the latched `mwe`/`madr`/`mwdata`.
  - `mack`=1 sampled at the edge: capture `mrdata` (reads only) and go to DONE.
  - Wait counter reaches `TIMEOUT` without `mack`: set the abort flag and go to DONE.
- **DONE**
  - Pulse the granted port's `*val` for exactly one cycle.
  - `err` equals the abort flag during this cycle.
  - Clear `grant` and go to IDLE.

Priority, evaluated in IDLE only:
- Normal order: `wreq` > `rreq` > `ireq`. Write first keeps dcache write-back before the refill read.
- Starvation counter `scnt`:
  - Increments on each data grant while `ireq` is high.
  - Clears on an instr grant, or in any IDLE cycle with `ireq` low.
  - Saturates at `MAXWAIT`.
- When `scnt`==`MAXWAIT` and `ireq` is high, instr wins over both data ports.

Data outputs:
- `idata`/`rdata` are registered and hold their last value until the next completed read for that port.
- On a timeout, the port's data output is loaded with 0.
- Writes never modify `idata`/`rdata`.

Boundary rules:
- `mack` in IDLE or DONE is ignored.
- A requester dropping `req` during ISSUE still gets its done pulse. No cancel exists.
- Simultaneous `ireq`, `rreq`, `wreq` with `scnt`<`MAXWAIT`: the write is served, then the read, then the instr.
- Reset mid-transaction: return to IDLE immediately and lose the transaction. Requesters re-issue.

## Timing
- All outputs are registered.
- Reset values: `idata`=0, `rdata`=0, `ival`=`rval`=`wval`=0, `mreq`=0, `mwe`=0, `madr`=0, `mwdata`=0, `err`=0, `grant`=0, `busy`=0, `scnt`=0.
- Example sequence:
  - Request high in IDLE cycle N.
  - `mreq` high in cycle N+1.
  - `mack` in cycle N+1+k, k≥0.
  - Done pulse in cycle N+2+k.
  - IDLE in cycle N+3+k.
- Minimum turnaround is 3 cycles per transaction. Back-to-back grants are separated by exactly one IDLE cycle.
- The wait counter starts at 0 on entry to ISSUE and increments every ISSUE cycle.
- Timeout fires when the counter equals `TIMEOUT`-1 with no `mack`, giving exactly `TIMEOUT` ISSUE cycles.
- `mack` arriving on the timeout cycle takes precedence: normal completion, `err`=0.

## Test plan
- **Reset:** assert `reset` mid-ISSUE (`madr`=0x40) -> all outputs 0 within the same cycle; the next `rreq` is served normally.
- **Single read:**
  - Stimulus: `rreq`, `radr`=0x100; memory returns `mrdata`=0xDEADBEEF with k=2.
  - Required: `rval` pulses 5 cycles after the request is first seen in IDLE; `rdata`=0xDEADBEEF and holds; `err`=0.
- **Contention:**
  - Stimulus: `ireq`, `rreq`, `wreq` rise together (`wadr`=0x200, `wdata`=0x12345678); memory with k=0.
  - Required: grant order 3, 2, 1; the memory model shows the write at 0x200 before the read; each `*val` pulses once.
- **Starvation:**
  - Stimulus: `ireq` held high; a new `rreq` is raised each IDLE cycle; `MAXWAIT`=4.
  - Required: exactly 4 read grants, then an instr grant, then `scnt` back to 0.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8, `mack` tied low, `ireq` at 0x300.
  - Required: `mreq` high for exactly 8 cycles; `ival`=1 and `err`=1 in the same cycle; `idata`=0; next state IDLE.
- **Late ack and protocol:**
  - Stimulus: `mack` on exactly the 8th ISSUE cycle; a stray `mack` pulse in IDLE; `rreq` dropped during ISSUE.
  - Required: normal completion with `err`=0; the stray `mack` causes no state change; `rval` still pulses for the dropped request.
